// File: rtl/hyperbus_burst_seq.sv
// Avalon-MM burst to HyperBus sequencer: CA phase, fixed/variable latency,
// multi-beat data phase, register-space access, read timeout and CS# high time.
//
// state | meaning
// IDLE  | waiting for an Avalon read or write; request accepted here
// CA0   | command/address word [47:32] on DQ
// CA1   | CA word [31:16]; RWDS sampled for the latency decision
// CA2   | CA word [15:0]; latency count loaded
// LAT   | initial latency (single or doubled)
// WDATA | write data, two DDR words per 32-bit beat
// RDATA | capturing read words, or zero-filling after a timeout
// CSHI  | chip select high for the minimum deselect time
module hyperbus_burst_seq #(
    parameter int ADDR_W        = 22,
    parameter int LATENCY_CLKS  = 6,
    parameter int FIXED_LATENCY = 0,
    parameter int MAX_BURST     = 16,
    parameter int BURSTCOUNT_W  = 5,
    parameter int TCSHI_CLKS    = 2,
    parameter int RD_TIMEOUT    = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             s0_address,
    input  logic                    s0_read,
    input  logic                    s0_write,
    input  logic [31:0]             s0_writedata,
    input  logic [BURSTCOUNT_W-1:0] s0_burstcount,
    output logic                    s0_waitrequest,
    output logic [31:0]             s0_readdata,
    output logic                    s0_readdatavalid,
    output logic                    csn,
    output logic                    oe_clk,
    output logic                    oe_data,
    output logic [15:0]             datain,
    input  logic [15:0]             dataout,
    input  logic                    rd_valid,
    input  logic                    rwds_in,
    output logic                    rwds_out,
    output logic                    rwds_oe,
    output logic                    busy,
    output logic                    lat_doubled,
    output logic                    err_timeout
);
    localparam int BEAT_W = $clog2(MAX_BURST + 1);
    localparam int LAT_W  = $clog2(2 * LATENCY_CLKS + 1);
    localparam int TMO_W  = $clog2(RD_TIMEOUT + 1);
    localparam int CSHI_W = $clog2(TCSHI_CLKS + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CA0   = 3'd1;
    localparam logic [2:0] S_CA1   = 3'd2;
    localparam logic [2:0] S_CA2   = 3'd3;
    localparam logic [2:0] S_LAT   = 3'd4;
    localparam logic [2:0] S_WDATA = 3'd5;
    localparam logic [2:0] S_RDATA = 3'd6;
    localparam logic [2:0] S_CSHI  = 3'd7;

    logic [2:0]        state;
    logic [47:0]       ca;
    logic              is_rd;
    logic              is_reg;
    logic              dbl;
    logic [BEAT_W-1:0] beats_left;
    logic [31:0]       wdata;
    logic              wphase;
    logic              rphase;
    logic [15:0]       rd_hi;
    logic              tmo_drain;
    logic [LAT_W-1:0]  lat_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [CSHI_W-1:0] cshi_cnt;

    logic [ADDR_W-1:0] word_addr;
    logic [28:0]       ca_row;
    logic [47:0]       ca_next;
    logic [31:0]       bc_ext;
    logic [31:0]       bc_clamp;
    logic [BEAT_W-1:0] beats_next;
    logic              req_ok;
    logic              wr_more;
    logic              last_beat;
    logic              unused_addr;

    assign unused_addr = ^{s0_address[30:ADDR_W+1], s0_address[0]};

    always_comb begin
        word_addr = s0_address[ADDR_W:1];
        ca_row    = '0;
        ca_row[ADDR_W-4:0] = word_addr[ADDR_W-1:3];
        ca_next   = {s0_read, s0_address[31], 1'b1, ca_row, 13'b0, word_addr[2:0]};

        bc_ext = 32'(s0_burstcount);
        if (s0_write && !s0_read && s0_address[31])
            bc_clamp = 32'd1;
        else if (bc_ext == 32'd0)
            bc_clamp = 32'd1;
        else if (bc_ext > 32'(MAX_BURST))
            bc_clamp = 32'(MAX_BURST);
        else
            bc_clamp = bc_ext;
        beats_next = BEAT_W'(bc_clamp);
    end

    assign last_beat = (beats_left == BEAT_W'(1));
    assign req_ok    = !rst && (state == S_IDLE) && (s0_read || s0_write);
    // The master must stream: the next beat is taken whether or not s0_write is up.
    assign wr_more   = !rst && (state == S_WDATA) && !is_reg && wphase && !last_beat;

    assign s0_waitrequest = !(req_ok || wr_more);
    assign busy           = (state != S_IDLE);
    assign rwds_out       = 1'b0;

    always_comb begin
        csn     = 1'b1;
        oe_clk  = 1'b0;
        oe_data = 1'b0;
        rwds_oe = 1'b0;
        datain  = '0;
        case (state)
            S_CA0: begin
                csn = 1'b0; oe_clk = 1'b1; oe_data = 1'b1; datain = ca[47:32];
            end
            S_CA1: begin
                csn = 1'b0; oe_clk = 1'b1; oe_data = 1'b1; datain = ca[31:16];
            end
            S_CA2: begin
                csn = 1'b0; oe_clk = 1'b1; oe_data = 1'b1; datain = ca[15:0];
            end
            S_LAT, S_RDATA: begin
                csn = 1'b0; oe_clk = 1'b1;
            end
            S_WDATA: begin
                csn     = 1'b0;
                oe_clk  = 1'b1;
                oe_data = 1'b1;
                rwds_oe = !is_reg;
                datain  = (is_reg || wphase) ? wdata[15:0] : wdata[31:16];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            ca               <= '0;
            is_rd            <= 1'b0;
            is_reg           <= 1'b0;
            dbl              <= 1'b0;
            beats_left       <= '0;
            wdata            <= '0;
            wphase           <= 1'b0;
            rphase           <= 1'b0;
            rd_hi            <= '0;
            tmo_drain        <= 1'b0;
            lat_cnt          <= '0;
            tmo_cnt          <= '0;
            cshi_cnt         <= '0;
            s0_readdata      <= '0;
            s0_readdatavalid <= 1'b0;
            lat_doubled      <= 1'b0;
            err_timeout      <= 1'b0;
        end else begin
            s0_readdatavalid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (s0_read || s0_write) begin
                        state      <= S_CA0;
                        ca         <= ca_next;
                        is_rd      <= s0_read;
                        is_reg     <= s0_address[31];
                        beats_left <= beats_next;
                        wdata      <= s0_writedata;
                    end
                end
                S_CA0: state <= S_CA1;
                S_CA1: begin
                    dbl   <= (FIXED_LATENCY != 0) || rwds_in;
                    state <= S_CA2;
                end
                S_CA2: begin
                    lat_doubled <= dbl;
                    if (!is_rd && is_reg) begin
                        state  <= S_WDATA;
                        wphase <= 1'b0;
                    end else begin
                        state   <= S_LAT;
                        lat_cnt <= dbl ? LAT_W'(2 * LATENCY_CLKS - 1) : LAT_W'(LATENCY_CLKS - 1);
                    end
                end
                S_LAT: begin
                    if (lat_cnt == '0) begin
                        if (is_rd) begin
                            state     <= S_RDATA;
                            rphase    <= 1'b0;
                            tmo_drain <= 1'b0;
                            tmo_cnt   <= TMO_W'(RD_TIMEOUT - 1);
                        end else begin
                            state  <= S_WDATA;
                            wphase <= 1'b0;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                S_WDATA: begin
                    if (is_reg || (wphase && last_beat)) begin
                        state    <= S_CSHI;
                        cshi_cnt <= CSHI_W'(TCSHI_CLKS - 1);
                    end else if (!wphase) begin
                        wphase <= 1'b1;
                    end else begin
                        beats_left <= beats_left - BEAT_W'(1);
                        wphase     <= 1'b0;
                        // Without a fresh beat the low word keeps being driven.
                        wdata      <= s0_write ? s0_writedata : {wdata[15:0], wdata[15:0]};
                    end
                end
                S_RDATA: begin
                    if (tmo_drain) begin
                        s0_readdata      <= '0;
                        s0_readdatavalid <= 1'b1;
                        if (last_beat) begin
                            state    <= S_CSHI;
                            cshi_cnt <= CSHI_W'(TCSHI_CLKS - 1);
                        end else begin
                            beats_left <= beats_left - BEAT_W'(1);
                        end
                    end else if (rd_valid) begin
                        tmo_cnt <= TMO_W'(RD_TIMEOUT - 1);
                        if (!rphase) begin
                            rd_hi  <= dataout;
                            rphase <= 1'b1;
                        end else begin
                            s0_readdata      <= {rd_hi, dataout};
                            s0_readdatavalid <= 1'b1;
                            rphase           <= 1'b0;
                            if (last_beat) begin
                                state    <= S_CSHI;
                                cshi_cnt <= CSHI_W'(TCSHI_CLKS - 1);
                            end else begin
                                beats_left <= beats_left - BEAT_W'(1);
                            end
                        end
                    end else if (tmo_cnt == '0) begin
                        err_timeout <= 1'b1;
                        tmo_drain   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt - TMO_W'(1);
                    end
                end
                S_CSHI: begin
                    if (cshi_cnt == '0)
                        state <= S_IDLE;
                    else
                        cshi_cnt <= cshi_cnt - CSHI_W'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hyperbus_burst_seq.sv
// Randomized and directed bench for hyperbus_burst_seq against a transaction-level model.
`timescale 1ns/1ps
module tb_hyperbus_burst_seq;
    localparam int LATC  = 6;
    localparam int TCSHI = 2;
    localparam int MAXB  = 16;
    localparam int BCW   = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic [31:0]    s0_address;
    logic           s0_read, s0_write;
    logic [31:0]    s0_writedata;
    logic [BCW-1:0] s0_burstcount;
    logic           s0_waitrequest;
    logic [31:0]    s0_readdata;
    logic           s0_readdatavalid;
    logic           csn, oe_clk, oe_data;
    logic [15:0]    datain, dataout;
    logic           rd_valid, rwds_in, rwds_out, rwds_oe;
    logic           busy, lat_doubled, err_timeout;

    always #5 clk = ~clk;

    hyperbus_burst_seq #(
        .ADDR_W(22), .LATENCY_CLKS(LATC), .FIXED_LATENCY(0), .MAX_BURST(MAXB),
        .BURSTCOUNT_W(BCW), .TCSHI_CLKS(TCSHI), .RD_TIMEOUT(64)
    ) dut (
        .clk(clk), .rst(rst),
        .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
        .s0_writedata(s0_writedata), .s0_burstcount(s0_burstcount),
        .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata),
        .s0_readdatavalid(s0_readdatavalid),
        .csn(csn), .oe_clk(oe_clk), .oe_data(oe_data), .datain(datain),
        .dataout(dataout), .rd_valid(rd_valid), .rwds_in(rwds_in),
        .rwds_out(rwds_out), .rwds_oe(rwds_oe), .busy(busy),
        .lat_doubled(lat_doubled), .err_timeout(err_timeout)
    );

    int total = 0;
    int bad   = 0;

    // per-transaction observations
    logic [15:0] ca_w[3];
    int          first_dk, bus_len, cshi_len, wreq_lo, nacc, sig_bad, rwds_oe_cnt;
    bit          txn_tmo;
    logic [15:0] wr_words[$];
    logic [31:0] rd_beats[$];
    int          off_k[$];
    logic [15:0] off_w[$];
    logic [31:0] wq[$];
    // model expectations
    logic [15:0] exp_words[$];
    logic [31:0] exp_beats[$];
    bit          exp_tmo;

    function automatic logic [47:0] model_ca(input bit rd, input logic [31:0] addr);
        logic [63:0] wa, v;
        wa = (64'(addr) >> 1) & 64'h3F_FFFF;
        v  = (64'(rd) << 47) | (64'(addr[31]) << 46) | (64'd1 << 45) | ((wa >> 3) << 16) | (wa & 64'd7);
        return v[47:0];
    endfunction

    function automatic int model_nb(input bit wr_reg, input int bc);
        if (wr_reg) return 1;
        if (bc == 0) return 1;
        if (bc > MAXB) return MAXB;
        return bc;
    endfunction

    // Read words offered at bus cycle >= 3+L are captured in order; short bursts zero-fill.
    task automatic model_read(input int nb, input int lat);
        logic [15:0] cap[$];
        exp_beats.delete();
        foreach (off_k[i])
            if (off_k[i] >= 3 + lat && cap.size() < 2 * nb) cap.push_back(off_w[i]);
        exp_tmo = (cap.size() < 2 * nb);
        for (int b = 0; b < nb; b++)
            if (2 * b + 1 < cap.size()) exp_beats.push_back({cap[2*b], cap[2*b+1]});
            else exp_beats.push_back(32'h0);
    endtask

    task automatic model_write(input bit is_reg);
        exp_words.delete();
        if (is_reg) exp_words.push_back(wq[0][15:0]);
        else foreach (wq[i]) begin
            exp_words.push_back(wq[i][31:16]);
            exp_words.push_back(wq[i][15:0]);
        end
    endtask

    task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr, input logic [BCW-1:0] bc,
                          input bit rwds, input int pct, input int start_k, input int max_words, input bit incr);
        int k, cyc, nwords;
        bit started, seen_busy, done;
        k = 0; cyc = 0; nwords = 0; started = 0; seen_busy = 0; done = 0;
        foreach (ca_w[i]) ca_w[i] = '0;
        first_dk = -1; cshi_len = 0; wreq_lo = 0; nacc = 0; sig_bad = 0; rwds_oe_cnt = 0;
        wr_words.delete(); rd_beats.delete(); off_k.delete(); off_w.delete();
        while (!done && cyc < 3000) begin
            @(posedge clk); #1;
            s0_read       = rd && !started;
            s0_write      = wr && !(rd && started) && (nacc < wq.size());
            s0_writedata  = (nacc < wq.size()) ? wq[nacc] : 32'h0;
            s0_address    = addr;
            s0_burstcount = bc;
            rwds_in       = rwds;
            if (!csn && k >= start_k && nwords < max_words && $urandom_range(99) < pct) begin
                rd_valid = 1'b1;
                dataout  = incr ? 16'(nwords + 1) : 16'($urandom);
                off_k.push_back(k);
                off_w.push_back(dataout);
                nwords++;
            end else begin
                rd_valid = 1'b0;
                dataout  = 16'($urandom);
            end
            #1;
            if (!s0_waitrequest) begin
                wreq_lo++;
                if (s0_write && !s0_read) nacc++;
                if (!busy) started = 1;
            end
            if (busy) seen_busy = 1;
            if (oe_clk !== !csn || rwds_out !== 1'b0) sig_bad++;
            if (!csn) begin
                if (k < 3) ca_w[k] = datain;
                else if (oe_data) begin
                    if (first_dk < 0) first_dk = k;
                    wr_words.push_back(datain);
                    if (rwds_oe) rwds_oe_cnt++;
                end
                k++;
            end else if (busy) cshi_len++;
            if (s0_readdatavalid) rd_beats.push_back(s0_readdata);
            if (started && seen_busy && !busy) done = 1;
            cyc++;
        end
        bus_len = k;
        txn_tmo = !done;
        s0_read = 0; s0_write = 0; rd_valid = 0;
    endtask

    task automatic test_reset;
        rst = 1; s0_read = 0; s0_write = 0; rd_valid = 0; rwds_in = 0;
        s0_address = 0; s0_writedata = 0; s0_burstcount = 0; dataout = 0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({csn, oe_clk, oe_data, rwds_oe, rwds_out, s0_waitrequest, s0_readdatavalid, busy, lat_doubled, err_timeout} !== 10'b10000_10000) begin
            bad++; $display("FAIL reset_ctrl: got %b want %b", {csn, oe_clk, oe_data, rwds_oe, rwds_out, s0_waitrequest, s0_readdatavalid, busy, lat_doubled, err_timeout}, 10'b10000_10000);
        end
        total++;
        if (datain !== 16'h0) begin bad++; $display("FAIL reset_datain: got %h want 0000", datain); end
        total++;
        if (s0_readdata !== 32'h0) begin bad++; $display("FAIL reset_readdata: got %h want 0", s0_readdata); end
        rst = 0;
    endtask

    task automatic test_single_write;
        logic [47:0] ca;
        wq.delete(); wq.push_back(32'hA5A5_5A5A);
        do_txn(0, 1, 32'h0000_0010, 5'd1, 0, 100, 0, 0, 0);
        ca = model_ca(0, 32'h0000_0010);
        model_write(0);
        total++;
        if (txn_tmo) begin bad++; $display("FAIL sw_done: got hang want completion"); end
        total++;
        if ({ca_w[0], ca_w[1], ca_w[2]} !== ca) begin bad++; $display("FAIL sw_ca: got %h want %h", {ca_w[0], ca_w[1], ca_w[2]}, ca); end
        total++;
        if (first_dk != 3 + LATC) begin bad++; $display("FAIL sw_latency: got %0d want %0d", first_dk - 3, LATC); end
        total++;
        if (wr_words != exp_words) begin bad++; $display("FAIL sw_data: got %p want %p", wr_words, exp_words); end
        total++;
        if (cshi_len != TCSHI) begin bad++; $display("FAIL sw_cshi: got %0d want %0d", cshi_len, TCSHI); end
        total++;
        if (lat_doubled !== 1'b0) begin bad++; $display("FAIL sw_latdbl: got %b want 0", lat_doubled); end
        total++;
        if (rwds_oe_cnt != 2 || wreq_lo != 1 || sig_bad != 0) begin
            bad++; $display("FAIL sw_ctrl: got rwds_oe=%0d wreq=%0d sig=%0d want 2 1 0", rwds_oe_cnt, wreq_lo, sig_bad);
        end
    endtask

    task automatic test_burst_read;
        logic [31:0] want[$];
        want = '{32'h0001_0002, 32'h0003_0004, 32'h0005_0006, 32'h0007_0008};
        wq.delete();
        do_txn(1, 0, 32'h0000_0100, 5'd4, 1, 100, 3 + 2 * LATC, 8, 1);
        total++;
        if (txn_tmo) begin bad++; $display("FAIL br_done: got hang want completion"); end
        total++;
        if ({ca_w[0], ca_w[1], ca_w[2]} !== model_ca(1, 32'h0000_0100)) begin
            bad++; $display("FAIL br_ca: got %h want %h", {ca_w[0], ca_w[1], ca_w[2]}, model_ca(1, 32'h0000_0100));
        end
        total++;
        if (rd_beats != want) begin bad++; $display("FAIL br_data: got %p want %p", rd_beats, want); end
        total++;
        if (lat_doubled !== 1'b1 || err_timeout !== 1'b0) begin
            bad++; $display("FAIL br_flags: got dbl=%b tmo=%b want 1 0", lat_doubled, err_timeout);
        end
    endtask

    task automatic test_reg_write;
        wq.delete(); wq.push_back(32'h0000_8F1F);
        do_txn(0, 1, 32'h8000_1000, 5'd3, 1, 100, 0, 0, 0);
        total++;
        if (ca_w[0] !== 16'h6000) begin bad++; $display("FAIL rw_ca0: got %h want 6000", ca_w[0]); end
        total++;
        if ({ca_w[0], ca_w[1], ca_w[2]} !== model_ca(0, 32'h8000_1000)) begin
            bad++; $display("FAIL rw_ca: got %h want %h", {ca_w[0], ca_w[1], ca_w[2]}, model_ca(0, 32'h8000_1000));
        end
        total++;
        if (first_dk != 3 || bus_len != 4) begin bad++; $display("FAIL rw_nolat: got first=%0d len=%0d want 3 4", first_dk, bus_len); end
        total++;
        if (wr_words.size() != 1 || wr_words[0] !== 16'h8F1F) begin bad++; $display("FAIL rw_data: got %p want 8f1f", wr_words); end
        total++;
        if (rwds_oe_cnt != 0 || wreq_lo != 1) begin bad++; $display("FAIL rw_ctrl: got rwds_oe=%0d wreq=%0d want 0 1", rwds_oe_cnt, wreq_lo); end
    endtask

    task automatic test_collision;
        wq.delete(); wq.push_back(32'hCAFE_F00D);
        do_txn(1, 1, 32'h0000_0A40, 5'd0, 0, 100, 0, 64, 0);
        model_read(1, LATC);
        total++;
        if (ca_w[0][15] !== 1'b1) begin bad++; $display("FAIL col_isread: got rd=%b want 1", ca_w[0][15]); end
        total++;
        if (rd_beats != exp_beats) begin bad++; $display("FAIL col_beats: got %p want %p", rd_beats, exp_beats); end
        total++;
        if (nacc != 0 || wreq_lo != 1) begin bad++; $display("FAIL col_accept: got wr_acc=%0d wreq=%0d want 0 1", nacc, wreq_lo); end
        do_txn(0, 1, 32'h0000_0A40, 5'd0, 0, 100, 0, 0, 0);
        model_write(0);
        total++;
        if (txn_tmo || wr_words != exp_words) begin bad++; $display("FAIL col_write: got %p want %p", wr_words, exp_words); end
    endtask

    task automatic test_random;
        for (int it = 0; it < 12; it++) begin
            bit rd, rwds, reg_wr;
            logic [31:0] addr;
            logic [BCW-1:0] bc;
            int nb, lat;
            rd     = 1'($urandom_range(1));
            rwds   = 1'($urandom_range(1));
            addr   = $urandom;
            bc     = BCW'($urandom_range(31));
            reg_wr = !rd && addr[31];
            nb     = model_nb(reg_wr, int'(bc));
            lat    = LATC * (rwds ? 2 : 1);
            wq.delete();
            if (!rd) for (int b = 0; b < nb; b++) wq.push_back($urandom);
            do_txn(rd, !rd, addr, bc, rwds, 40 + $urandom_range(60), 0, 1000, 0);
            total++;
            if (txn_tmo || {ca_w[0], ca_w[1], ca_w[2]} !== model_ca(rd, addr)) begin
                bad++; $display("FAIL rnd_ca[%0d]: got %h want %h", it, {ca_w[0], ca_w[1], ca_w[2]}, model_ca(rd, addr));
            end
            if (rd) begin
                model_read(nb, lat);
                total++;
                if (rd_beats != exp_beats) begin bad++; $display("FAIL rnd_rdata[%0d]: got %p want %p", it, rd_beats, exp_beats); end
            end else begin
                model_write(reg_wr);
                total++;
                if (wr_words != exp_words || first_dk != (reg_wr ? 3 : 3 + lat)) begin
                    bad++; $display("FAIL rnd_wdata[%0d]: got first=%0d %p want first=%0d %p", it, first_dk, wr_words, reg_wr ? 3 : 3 + lat, exp_words);
                end
                total++;
                if (wreq_lo != nb) begin bad++; $display("FAIL rnd_accepts[%0d]: got %0d want %0d", it, wreq_lo, nb); end
            end
            if (!reg_wr) begin
                total++;
                if (lat_doubled !== rwds) begin bad++; $display("FAIL rnd_latdbl[%0d]: got %b want %b", it, lat_doubled, rwds); end
            end
            total++;
            if (cshi_len != TCSHI || sig_bad != 0) begin bad++; $display("FAIL rnd_cshi[%0d]: got cshi=%0d sig=%0d want %0d 0", it, cshi_len, sig_bad, TCSHI); end
        end
    endtask

    task automatic test_timeout;
        logic [31:0] zz[$];
        zz = '{32'h0, 32'h0};
        total++;
        if (err_timeout !== 1'b0) begin bad++; $display("FAIL to_pre: got %b want 0", err_timeout); end
        wq.delete();
        do_txn(1, 0, 32'h0000_0200, 5'd2, 0, 100, 3 + LATC, 1, 0);
        total++;
        if (txn_tmo) begin bad++; $display("FAIL to_done: got hang want return to idle"); end
        total++;
        if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_flag: got %b want 1", err_timeout); end
        total++;
        if (rd_beats != zz) begin bad++; $display("FAIL to_beats: got %p want %p", rd_beats, zz); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL to_idle: got busy=%b want 0", busy); end
        do_txn(1, 0, 32'h0000_0300, 5'd1, 0, 100, 0, 64, 0);
        model_read(1, LATC);
        total++;
        if (err_timeout !== 1'b1 || rd_beats != exp_beats) begin
            bad++; $display("FAIL to_sticky: got flag=%b %p want 1 %p", err_timeout, rd_beats, exp_beats);
        end
    endtask

    task automatic test_reset_mid;
        int cnt, nrdv, nbusy;
        cnt = 0; nrdv = 0; nbusy = 0;
        @(posedge clk); #1;
        s0_address = 32'h0000_0400; s0_burstcount = 5'd4; rwds_in = 0; s0_read = 1;
        for (int i = 0; i < 30 && cnt < 6; i++) begin
            @(posedge clk); #1;
            s0_read = 0;
            if (!csn) cnt++;
        end
        total++;
        if (cnt != 6) begin bad++; $display("FAIL rm_start: got %0d bus cycles want 6", cnt); end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        total++;
        if ({csn, oe_clk, oe_data, rwds_oe, busy, lat_doubled, err_timeout} !== 7'b1000000) begin
            bad++; $display("FAIL rm_state: got %b want 1000000", {csn, oe_clk, oe_data, rwds_oe, busy, lat_doubled, err_timeout});
        end
        for (int i = 0; i < 30; i++) begin
            rd_valid = 1; dataout = 16'($urandom);
            @(posedge clk); #1;
            if (s0_readdatavalid) nrdv++;
            if (busy) nbusy++;
        end
        rd_valid = 0;
        total++;
        if (nrdv != 0 || nbusy != 0) begin bad++; $display("FAIL rm_quiet: got rdv=%0d busy=%0d want 0 0", nrdv, nbusy); end
        wq.delete(); wq.push_back(32'h1357_9BDF); wq.push_back(32'h2468_ACE0);
        do_txn(0, 1, 32'h0001_2344, 5'd2, 0, 100, 0, 0, 0);
        model_write(0);
        total++;
        if (txn_tmo || wr_words != exp_words || first_dk != 3 + LATC) begin
            bad++; $display("FAIL rm_write: got first=%0d %p want first=%0d %p", first_dk, wr_words, 3 + LATC, exp_words);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_burst_read();
        test_reg_write();
        test_collision();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
